alu_control_unit: RTL and testbench

//  Sequencing control unit that drives the 32-bit ALU: accepts instruction words, reads operands

---
 rtl/alu_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_alu_control_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_unit
// Brief    : Fetches operands from an 8-entry register file, drives the
//            external 32-bit ALU, and writes back the result plus C/Z/N flags.
//            Optional macro ALU_CU_IMM_EN: instr[15] selects a zero-extended
//            15-bit immediate as operand b.
// Revision : 1.0  initial release
// ============================================================================
module alu_control_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [5:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic                  alu_c,
    input  logic [DATA_W-1:0]     alu_res,
    input  logic                  alu_cout,
    input  logic                  alu_z,
    input  logic                  alu_n,
    input  logic                  rf_wr_en,
    input  logic [REG_ADDR_W-1:0] rf_wr_addr,
    input  logic [DATA_W-1:0]     rf_wr_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  illegal_op
);

    localparam int c_NREGS = 2 ** REG_ADDR_W;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_DECODE    = 2'd1;
    localparam logic [1:0] c_ST_EXECUTE   = 2'd2;
    localparam logic [1:0] c_ST_WRITEBACK = 2'd3;

    localparam logic [5:0] c_OP_ADD = 6'b010000;
    localparam logic [5:0] c_OP_SUB = 6'b010001;
    localparam logic [5:0] c_OP_EQ  = 6'b100000;
    localparam logic [5:0] c_OP_LLS = 6'b110000;
    localparam logic [5:0] c_OP_LRS = 6'b110001;
    localparam logic [5:0] c_OP_ARS = 6'b110010;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [DATA_W-1:0]     r_rf [c_NREGS];

    logic [5:0]            r_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic                  r_cin_sel;

    logic [DATA_W-1:0]     r_res;
    logic                  r_cout;
    logic                  r_z;
    logic                  r_n;

    logic                  w_legal;
    logic                  w_carry_op;
    logic [DATA_W-1:0]     w_opnd_b;

`ifdef ALU_CU_IMM_EN
    logic                  r_imm_sel;
    logic [14:0]           r_imm;

    assign w_opnd_b = r_imm_sel ? {{(DATA_W-15){1'b0}}, r_imm} : r_rf[r_rs2];
`else
    logic                  w_unused_imm;

    // Immediate field has no consumer in this build
    assign w_unused_imm = &{1'b0, instr[15:0]};
    assign w_opnd_b     = r_rf[r_rs2];
`endif

    always_comb begin
        case (r_op)
            c_OP_ADD, c_OP_SUB, c_OP_EQ,
            c_OP_LLS, c_OP_LRS, c_OP_ARS: w_legal = 1'b1;
            default:                      w_legal = 1'b0;
        endcase
    end

    assign w_carry_op = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
    assign dbg_data   = r_rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:      if (instr_valid) w_next_state = c_ST_DECODE;
            c_ST_DECODE:    w_next_state = w_legal ? c_ST_EXECUTE : c_ST_IDLE;
            c_ST_EXECUTE:   w_next_state = c_ST_WRITEBACK;
            c_ST_WRITEBACK: w_next_state = c_ST_IDLE;
            default:        w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (r_state == c_ST_IDLE);
        illegal_op  = (r_state == c_ST_DECODE) && !w_legal;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_rf[i] <= '0;
            end
            r_op      <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_cin_sel <= 1'b0;
`ifdef ALU_CU_IMM_EN
            r_imm_sel <= 1'b0;
            r_imm     <= '0;
`endif
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_c     <= 1'b0;
            r_res     <= '0;
            r_cout    <= 1'b0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Host write and instruction accept may share a cycle;
                    // operands are read a cycle later, so the write is seen.
                    if (rf_wr_en) begin
                        r_rf[rf_wr_addr] <= rf_wr_data;
                    end
                    if (instr_valid) begin
                        r_op      <= instr[31:26];
                        r_rd      <= instr[25:23];
                        r_rs1     <= instr[22:20];
                        r_rs2     <= instr[19:17];
                        r_cin_sel <= instr[16];
`ifdef ALU_CU_IMM_EN
                        r_imm_sel <= instr[15];
                        r_imm     <= instr[14:0];
`endif
                    end
                end
                c_ST_DECODE: begin
                    if (w_legal) begin
                        alu_op <= r_op;
                        alu_a  <= r_rf[r_rs1];
                        alu_b  <= w_opnd_b;
                        alu_c  <= r_cin_sel & flag_c;
                    end
                end
                c_ST_EXECUTE: begin
                    r_res  <= alu_res;
                    r_cout <= alu_cout;
                    r_z    <= alu_z;
                    r_n    <= alu_n;
                end
                c_ST_WRITEBACK: begin
                    r_rf[r_rd] <= r_res;
                    flag_z     <= r_z;
                    flag_n     <= r_n;
                    if (w_carry_op) begin
                        flag_c <= r_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_unit
// Brief    : Randomised and directed bench for alu_control_unit with a
//            behavioural ALU, a reference model and a scoreboard monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_control_unit;

    localparam logic [5:0] c_ADD = 6'b010000;
    localparam logic [5:0] c_SUB = 6'b010001;
    localparam logic [5:0] c_EQ  = 6'b100000;
    localparam logic [5:0] c_LLS = 6'b110000;
    localparam logic [5:0] c_LRS = 6'b110001;
    localparam logic [5:0] c_ARS = 6'b110010;
    localparam logic [5:0] c_LEGAL [6] = '{c_ADD, c_SUB, c_EQ, c_LLS, c_LRS, c_ARS};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_c;
    logic [31:0] alu_res;
    logic        alu_cout;
    logic        alu_z;
    logic        alu_n;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0][31:0] rf;
        logic             fc;
        logic             fz;
        logic             fn;
        logic [5:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic             c;
        logic             ill;
        logic [1:0]       busy;
    } exp_t;

    exp_t sbq [$];

    // Reference machine state
    logic [7:0][31:0] m_rf;
    logic             m_fc, m_fz, m_fn;
    logic [5:0]       m_op;
    logic [31:0]      m_a, m_b;
    logic             m_c;

    alu_control_unit #(.DATA_W(32), .REG_ADDR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .illegal_op (illegal_op)
    );

    always #10 clk = ~clk;

    // Behavioural ALU: {carry/borrow, result}
    function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
        case (op)
            c_ADD:   return {1'b0, a} + {1'b0, b} + {32'd0, c};
            c_SUB:   return {1'b0, a} - {1'b0, b} - {32'd0, c};
            c_EQ:    return {32'd0, (a == b)};
            c_LLS:   return {1'b0, a << b};
            c_LRS:   return {1'b0, a >> b};
            c_ARS:   return {1'b0, 32'($signed(a) >>> b)};
            default: return 33'd0;
        endcase
    endfunction

    always_comb begin
        {alu_cout, alu_res} = alu_fn(alu_op, alu_a, alu_b, alu_c);
        alu_z = (alu_res == 32'd0);
        alu_n = alu_res[31];
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic cin, input logic isel, input logic [14:0] imm);
        return {op, rd, rs1, rs2, cin, isel, imm};
    endfunction

    function automatic void model_reset();
        m_rf = '0;
        m_fc = 1'b0; m_fz = 1'b0; m_fn = 1'b0;
        m_op = '0;   m_a = '0;    m_b = '0;  m_c = 1'b0;
    endfunction

    function automatic void model_exec(input logic [31:0] iw);
        exp_t        e;
        logic [5:0]  op;
        logic [32:0] r;
        bit          legal;
        op    = iw[31:26];
        legal = 1'b0;
        foreach (c_LEGAL[k]) if (c_LEGAL[k] == op) legal = 1'b1;
        if (legal) begin
            m_op = op;
            m_a  = m_rf[iw[22:20]];
            m_b  = m_rf[iw[19:17]];
`ifdef ALU_CU_IMM_EN
            if (iw[15]) m_b = {17'd0, iw[14:0]};
`endif
            m_c  = iw[16] ? m_fc : 1'b0;
            r    = alu_fn(m_op, m_a, m_b, m_c);
            m_rf[iw[25:23]] = r[31:0];
            m_fz = (r[31:0] == 32'd0);
            m_fn = r[31];
            if (op == c_ADD || op == c_SUB) m_fc = r[32];
        end
        e.rf = m_rf; e.fc = m_fc; e.fz = m_fz; e.fn = m_fn;
        e.op = m_op; e.a = m_a; e.b = m_b; e.c = m_c;
        e.ill  = !legal;
        e.busy = legal ? 2'd3 : 2'd1;
        sbq.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        rf_wr_en = 1'b1; rf_wr_addr = a; rf_wr_data = d;
        m_rf[a] = d;
        step();
        rf_wr_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] iw, input bit hw, input logic [2:0] ha,
                        input logic [31:0] hd, input bit track);
        int guard = 0;
        while (!instr_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
        instr = iw; instr_valid = 1'b1;
        rf_wr_en = hw; rf_wr_addr = ha; rf_wr_data = hd;
        if (hw) m_rf[ha] = hd;
        if (track) model_exec(iw);
        step();
        instr_valid = 1'b0;
        rf_wr_en    = 1'b0;
    endtask

    // Host writes while busy must be ignored
    task automatic finish_instr();
        int guard = 0;
        while (!instr_ready && guard < 50) begin
            rf_wr_en   = 1'($urandom);
            rf_wr_addr = 3'($urandom);
            rf_wr_data = $urandom;
            step();
            guard++;
        end
        rf_wr_en = 1'b0;
        if (!instr_ready) chk("busy_timeout", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic run(input logic [31:0] iw, input bit hw, input logic [2:0] ha, input logic [31:0] hd);
        send(iw, hw, ha, hd, 1'b1);
        finish_instr();
    endtask

    initial begin : monitor
        exp_t e;
        int   low  = 0;
        int   ill  = 0;
        bit   busy = 1'b0;
        dbg_addr = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0; low = 0; ill = 0;
            end else if (!instr_ready) begin
                busy = 1'b1;
                low++;
                if (illegal_op) ill++;
            end else if (busy) begin
                busy = 1'b0;
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("busy_cycles", low, {30'd0, e.busy});
                    chk("illegal_pulses", ill, {31'd0, e.ill});
                    chk("flag_c", {31'd0, flag_c}, {31'd0, e.fc});
                    chk("flag_z", {31'd0, flag_z}, {31'd0, e.fz});
                    chk("flag_n", {31'd0, flag_n}, {31'd0, e.fn});
                    chk("alu_op", {26'd0, alu_op}, {26'd0, e.op});
                    chk("alu_a", alu_a, e.a);
                    chk("alu_b", alu_b, e.b);
                    chk("alu_c", {31'd0, alu_c}, {31'd0, e.c});
                    for (int r = 0; r < 8; r++) begin
                        dbg_addr = 3'(r);
                        #1;
                        chk($sformatf("reg%0d", r), dbg_data, e.rf[r]);
                    end
                end
                low = 0; ill = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        rf_wr_en = 1'b0; rf_wr_addr = '0; rf_wr_data = '0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
        chk("reset_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
        chk("reset_alu_op", {26'd0, alu_op}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);

        host_write(3'd1, 32'd5); host_write(3'd2, 32'd3);
        run(mk(c_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);

        host_write(3'd1, 32'd3); host_write(3'd2, 32'd5);
        run(mk(c_SUB, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);
        run(mk(c_ADD, 3'd6, 3'd1, 3'd2, 1'b1, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);

        host_write(3'd1, 32'd7); host_write(3'd2, 32'd7);
        run(mk(c_EQ, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);
        host_write(3'd1, 32'd1); host_write(3'd2, 32'd4);
        run(mk(c_LLS, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);
        host_write(3'd1, 32'h8000_0000);
        run(mk(c_ARS, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);
        run(mk(c_LRS, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);

        run(mk(6'b111111, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);

        host_write(3'd1, 32'd10);
        run(mk(c_ADD, 3'd2, 3'd1, 3'd4, 1'b0, 1'b1, 15'h7FFF), 1'b0, 3'd0, 32'd0);

        // Accept and host write in the same cycle: operand sees the new value
        run(mk(c_ADD, 3'd5, 3'd6, 3'd6, 1'b0, 1'b0, 15'd0), 1'b1, 3'd6, 32'h1234_5678);

        // Reset during EXECUTE must abort the writeback
        host_write(3'd1, 32'd5); host_write(3'd2, 32'd3);
        send(mk(c_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
        chk("abort_alu_op", {26'd0, alu_op}, 32'd0);
        run(mk(c_ADD, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 15'd0), 1'b0, 3'd0, 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [5:0]  op;
            logic [31:0] d;
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else                           op = c_LEGAL[$urandom_range(0, 5)];
            case ($urandom_range(0, 4))
                0:       d = 32'd0;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'h8000_0000;
                3:       d = 32'($urandom_range(0, 40));
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) host_write(3'($urandom), 32'($urandom_range(0, 35)));
            run(mk(op, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                   1'($urandom), 15'($urandom)),
                1'($urandom), 3'($urandom), d);
        end

        repeat (6) step();
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
